// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared policy entry and checker state types
package pu_pkg;

   typedef struct packed {
      logic read;
      logic write;
   } policy_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      FWD,
      ERR
   } pu_chk_state_t;

endpackage

// File: rtl/pu_policy_table.sv
// rtl/pu_policy_table.sv - registered per-region permission table
// One write port, one combinational read port; reset leaves every region deny-all.
module pu_policy_table
   import pu_pkg::*;
#(
   parameter int NUM_REGIONS = 8,
   localparam int IDX_W = $clog2(NUM_REGIONS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  policy_entry_t    wdata_i,
   input  logic [IDX_W-1:0] ridx_i,
   output policy_entry_t    rdata_o
);

   policy_entry_t entries_q [NUM_REGIONS];
   policy_entry_t entries_d [NUM_REGIONS];

   always_comb begin
      entries_d = entries_q;
      if (we_i) begin
         entries_d[widx_i] = wdata_i;
      end
   end

   // Reset takes priority, so a write strobe during reset is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         entries_q <= entries_d;
      end
   end

   // Reads the registered value, so a same-cycle write is seen only afterwards.
   assign rdata_o = entries_q[ridx_i];

endmodule

// File: rtl/pu_access_checker.sv
// rtl/pu_access_checker.sv - region-based read/write permission checker
// Latches a request, looks up its region policy, then forwards it or returns an error.
module pu_access_checker
   import pu_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int NUM_REGIONS  = 8,
   parameter int REGION_SHIFT = 12,
   localparam int IDX_W = $clog2(NUM_REGIONS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  policy_entry_t     cfg_policy_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              req_write_i,
   output logic              fwd_valid_o,
   input  logic              fwd_ready_i,
   output logic [ADDR_W-1:0] fwd_addr_o,
   output logic              fwd_write_o,
   output logic              err_valid_o,
   input  logic              err_ready_i,
   output logic [15:0]       viol_count_o,
   output logic [ADDR_W-1:0] viol_addr_o
);

   pu_chk_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [15:0]       viol_count_q, viol_count_d;
   logic [ADDR_W-1:0] viol_addr_q, viol_addr_d;

   logic [IDX_W-1:0]  lookup_idx;
   policy_entry_t     lookup_entry;
   logic              in_range;
   logic              permit;

   pu_policy_table #(
      .NUM_REGIONS(NUM_REGIONS)
   ) u_table (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .we_i   (cfg_we_i),
      .widx_i (cfg_idx_i),
      .wdata_i(cfg_policy_i),
      .ridx_i (lookup_idx),
      .rdata_o(lookup_entry)
   );

   // Addresses beyond the last table region are denied outright.
   assign lookup_idx = addr_q[REGION_SHIFT +: IDX_W];
   assign in_range   = (addr_q >> (REGION_SHIFT + IDX_W)) == '0;
   assign permit     = in_range && (write_q ? lookup_entry.write : lookup_entry.read);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      write_d      = write_q;
      viol_count_d = viol_count_q;
      viol_addr_d  = viol_addr_q;
      req_ready_o  = 1'b0;
      fwd_valid_o  = 1'b0;
      fwd_addr_o   = '0;
      fwd_write_o  = 1'b0;
      err_valid_o  = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               write_d = req_write_i;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (permit) begin
               state_d = FWD;
            end else begin
               state_d      = ERR;
               viol_addr_d  = addr_q;
               viol_count_d = (viol_count_q == 16'hFFFF) ? viol_count_q : viol_count_q + 16'd1;
            end
         end
         FWD: begin
            fwd_valid_o = 1'b1;
            fwd_addr_o  = addr_q;
            fwd_write_o = write_q;
            if (fwd_ready_i) begin
               state_d = IDLE;
            end
         end
         ERR: begin
            err_valid_o = 1'b1;
            if (err_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         write_q      <= 1'b0;
         viol_count_q <= '0;
         viol_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         viol_count_q <= viol_count_d;
         viol_addr_q  <= viol_addr_d;
      end
   end

   assign viol_count_o = viol_count_q;
   assign viol_addr_o  = viol_addr_q;

endmodule

// File: tb/tb_pu_access_checker.sv
// tb/tb_pu_access_checker.sv - directed vector bench for pu_access_checker
module tb_pu_access_checker;
   import pu_pkg::*;

   localparam int ADDR_W = 32;
   localparam int IDX_W  = 3;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              cfg_we_i;
   logic [IDX_W-1:0]  cfg_idx_i;
   policy_entry_t     cfg_policy_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [ADDR_W-1:0] req_addr_i;
   logic              req_write_i;
   logic              fwd_valid_o;
   logic              fwd_ready_i;
   logic [ADDR_W-1:0] fwd_addr_o;
   logic              fwd_write_o;
   logic              err_valid_o;
   logic              err_ready_i;
   logic [15:0]       viol_count_o;
   logic [ADDR_W-1:0] viol_addr_o;

   int total  = 0;
   int passed = 0;

   pu_access_checker dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_idx_i   (cfg_idx_i),
      .cfg_policy_i(cfg_policy_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_write_i (req_write_i),
      .fwd_valid_o (fwd_valid_o),
      .fwd_ready_i (fwd_ready_i),
      .fwd_addr_o  (fwd_addr_o),
      .fwd_write_o (fwd_write_o),
      .err_valid_o (err_valid_o),
      .err_ready_i (err_ready_i),
      .viol_count_o(viol_count_o),
      .viol_addr_o (viol_addr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cfg_we;
      logic [2:0]  cfg_idx;
      logic        cfg_rd;
      logic        cfg_wr;
      logic [31:0] addr;
      logic        wr;
      logic        exp_fwd;
      logic [15:0] exp_cnt;
      logic [31:0] exp_vaddr;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // All tasks start and end right after a falling edge.
   task automatic do_cfg(input logic [2:0] idx, input logic rd, input logic wr);
      cfg_we_i     = 1'b1;
      cfg_idx_i    = idx;
      cfg_policy_i = '{read: rd, write: wr};
      @(negedge clk);
      cfg_we_i = 1'b0;
   endtask

   task automatic do_req(input string tag, input logic [31:0] a, input logic w, input logic exp_fwd);
      check({tag, " ready"}, req_ready_o, 1);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_write_i = w;
      @(negedge clk);
      req_valid_i = 1'b0;
      check({tag, " check_phase"}, {req_ready_o, fwd_valid_o, err_valid_o}, 3'b000);
      @(negedge clk);
      check({tag, " fwd_valid"}, fwd_valid_o, exp_fwd);
      check({tag, " err_valid"}, err_valid_o, !exp_fwd);
      if (exp_fwd) begin
         check({tag, " fwd_addr"}, fwd_addr_o, a);
         check({tag, " fwd_write"}, fwd_write_o, w);
      end
      fwd_ready_i = exp_fwd;
      err_ready_i = !exp_fwd;
      @(negedge clk);
      fwd_ready_i = 1'b0;
      err_ready_i = 1'b0;
      check({tag, " back_idle"}, {req_ready_o, fwd_valid_o, err_valid_o}, 3'b100);
   endtask

   initial begin
      logic [31:0] hold_addr;

      vecs[0] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 16'd1, 32'h0000_1000};
      vecs[1] = '{1'b1, 3'd2, 1'b1, 1'b0, 32'h0000_2040, 1'b0, 1'b1, 16'd1, 32'h0000_1000};
      vecs[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_2040, 1'b1, 1'b0, 16'd2, 32'h0000_2040};
      vecs[3] = '{1'b1, 3'd0, 1'b1, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 16'd3, 32'h0001_0000};
      vecs[4] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 16'd3, 32'h0001_0000};
      vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0FF0, 1'b1, 1'b1, 16'd3, 32'h0001_0000};
      vecs[6] = '{1'b1, 3'd7, 1'b0, 1'b1, 32'h0000_7FFC, 1'b1, 1'b1, 16'd3, 32'h0001_0000};
      vecs[7] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_7000, 1'b0, 1'b0, 16'd4, 32'h0000_7000};
      vecs[8] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 16'd5, 32'h8000_0000};
      vecs[9] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_8000, 1'b1, 1'b0, 16'd6, 32'h0000_8000};

      rst_i        = 1'b1;
      cfg_we_i     = 1'b0;
      cfg_idx_i    = '0;
      cfg_policy_i = '0;
      req_valid_i  = 1'b0;
      req_addr_i   = '0;
      req_write_i  = 1'b0;
      fwd_ready_i  = 1'b0;
      err_ready_i  = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("reset outputs", {req_ready_o, fwd_valid_o, err_valid_o}, 3'b100);
      check("reset count", viol_count_o, 0);
      check("reset vaddr", viol_addr_o, 0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].cfg_we) do_cfg(vecs[i].cfg_idx, vecs[i].cfg_rd, vecs[i].cfg_wr);
         do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].exp_fwd);
         check($sformatf("vec%0d count", i), viol_count_o, vecs[i].exp_cnt);
         check($sformatf("vec%0d vaddr", i), viol_addr_o, vecs[i].exp_vaddr);
      end

      // Backpressured forward: outputs hold, new requests are ignored.
      do_cfg(3'd1, 1'b1, 1'b0);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_1234;
      req_write_i = 1'b0;
      @(negedge clk);
      req_addr_i  = 32'h0000_1F00;
      req_write_i = 1'b1;
      @(negedge clk);
      hold_addr = 32'h0000_1234;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d", c),
               {req_ready_o, fwd_valid_o, err_valid_o, fwd_write_o, fwd_addr_o},
               {4'b0100, hold_addr});
         @(negedge clk);
      end
      req_valid_i = 1'b0;
      fwd_ready_i = 1'b1;
      @(negedge clk);
      fwd_ready_i = 1'b0;
      check("stall release idle", {req_ready_o, fwd_valid_o, err_valid_o}, 3'b100);
      check("stall no violation", viol_count_o, 6);

      // Policy write during CHECK of the same region applies only afterwards.
      do_cfg(3'd3, 1'b1, 1'b1);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_3000;
      req_write_i = 1'b0;
      @(negedge clk);
      req_valid_i  = 1'b0;
      cfg_we_i     = 1'b1;
      cfg_idx_i    = 3'd3;
      cfg_policy_i = '{read: 1'b0, write: 1'b0};
      @(negedge clk);
      cfg_we_i = 1'b0;
      check("race old policy fwd", {fwd_valid_o, err_valid_o}, 2'b10);
      fwd_ready_i = 1'b1;
      @(negedge clk);
      fwd_ready_i = 1'b0;
      do_req("race new policy", 32'h0000_3000, 1'b0, 1'b0);
      check("race count", viol_count_o, 7);

      // Saturation: preload the counter near its ceiling instead of 65k denials.
      force dut.viol_count_q = 16'hFFFD;
      @(negedge clk);
      release dut.viol_count_q;
      do_req("sat a", 32'h0000_1000, 1'b1, 1'b0);
      check("sat count a", viol_count_o, 16'hFFFE);
      do_req("sat b", 32'h0000_1004, 1'b1, 1'b0);
      check("sat count b", viol_count_o, 16'hFFFF);
      do_req("sat c", 32'h0000_1008, 1'b1, 1'b0);
      check("sat count c", viol_count_o, 16'hFFFF);
      check("sat vaddr", viol_addr_o, 32'h0000_1008);

      // Reset while forwarding, with a config write that must be ignored.
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_2040;
      req_write_i = 1'b0;
      @(negedge clk);
      req_valid_i = 1'b0;
      @(negedge clk);
      check("pre-reset fwd", fwd_valid_o, 1);
      rst_i        = 1'b1;
      cfg_we_i     = 1'b1;
      cfg_idx_i    = 3'd2;
      cfg_policy_i = '{read: 1'b1, write: 1'b1};
      @(negedge clk);
      check("rst fwd dropped", {fwd_valid_o, err_valid_o}, 2'b00);
      check("rst count", viol_count_o, 0);
      check("rst vaddr", viol_addr_o, 0);
      rst_i    = 1'b0;
      cfg_we_i = 1'b0;
      @(negedge clk);
      check("post-rst ready", req_ready_o, 1);
      do_req("post-rst deny", 32'h0000_2040, 1'b0, 1'b0);
      check("post-rst count", viol_count_o, 1);

      // Reset during CHECK of a denied request must not count it.
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_5000;
      @(negedge clk);
      req_valid_i = 1'b0;
      rst_i       = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("rst in check", {req_ready_o, err_valid_o, viol_count_o}, {2'b10, 16'd0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
